// File: rtl/mem_io_responder_pkg.sv
// Shared constants, read-source encoding and IO decode for the memory/IO responder.
package mem_io_responder_pkg;

  localparam logic [31:0] IO_BASE  = 32'h0003_0000;
  localparam logic [31:0] IO_STOP  = 32'h0003_0004;
  localparam logic [2:0]  OFF_DATA = IO_BASE[2:0];
  localparam logic [2:0]  OFF_STOP = IO_STOP[2:0];

  typedef enum logic [1:0] {
    SRC_RAM,
    SRC_RX,
    SRC_CNT,
    SRC_ZERO
  } rd_src_e;

  function automatic logic is_io(input logic [1:0] a_17_16);
    return a_17_16 == 2'b11;
  endfunction

endpackage

// File: rtl/mem_io_responder_byte_fifo.sv
// Circular-buffer FIFO with occupancy count; storage is not reset.
module byte_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          push_i,
  input  logic [W-1:0]  push_data_i,
  input  logic          pop_i,
  output logic [W-1:0]  pop_data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o     = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = mem[rd_ptr_q];
  assign do_push    = push_i && !full_o;
  assign do_pop     = pop_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push) mem[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/mem_io_responder.sv
// CPU byte-bus responder: unified RAM, IO window (RX/TX/counter/stop) and CPU stall control.
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int RAM_AW   = 17,
  parameter int TX_DEPTH = 8,
  parameter int CNT_W    = 32
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] cpu_a_i,
  input  logic [7:0]  cpu_dout_i,
  input  logic        cpu_wr_i,
  output logic [7:0]  cpu_din_o,
  output logic        cpu_rdy_o,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic        prog_stop_o
);

  localparam int TX_CW = $clog2(TX_DEPTH) + 1;

  logic [7:0]        ram [2**RAM_AW];
  logic [7:0]        ram_q;
  logic [RAM_AW-1:0] ram_addr;

  logic [31:0]       prev_a_q, prev_a_d;
  logic              prev_wr_q, prev_wr_d, prev_vld_q, prev_vld_d;
  rd_src_e           src_q, src_d;
  logic [7:0]        io_q, io_d;
  logic              rx_full_q, rx_full_d;
  logic [7:0]        rx_data_q, rx_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, snap_q, snap_d, snap_sel;
  logic [31:0]       snap_w;
  logic              stop_q, stop_d;

  logic              acc, rd_acc, wr_acc, new_rd, io_hit;
  logic [2:0]        io_off;
  logic              tx_push, tx_full, tx_empty;
  logic [7:0]        tx_wdata;
  logic [TX_CW-1:0]  tx_cnt;

  assign io_hit   = is_io(cpu_a_i[17:16]);
  assign io_off   = cpu_a_i[2:0];
  assign ram_addr = cpu_a_i[RAM_AW-1:0];

  assign cpu_rdy_o   = !stop_q && (tx_cnt < TX_CW'(TX_DEPTH));
  assign acc         = cpu_rdy_o;
  assign rd_acc      = acc && !cpu_wr_i;
  assign wr_acc      = acc && cpu_wr_i;
  assign new_rd      = rd_acc && (!prev_vld_q || prev_wr_q || (cpu_a_i != prev_a_q));
  assign rx_ready_o  = !rx_full_q;
  assign tx_valid_o  = !tx_empty;
  assign prog_stop_o = stop_q;

  // A fresh read of the stop offset reads the live counter and latches it.
  always_comb begin
    snap_d   = snap_q;
    snap_sel = snap_q;
    if (new_rd && io_hit && (io_off == OFF_STOP)) begin
      snap_d   = cnt_q;
      snap_sel = cnt_q;
    end
    snap_w = 32'(snap_sel);
  end

  always_comb begin
    prev_a_d   = prev_a_q;
    prev_wr_d  = prev_wr_q;
    prev_vld_d = prev_vld_q;
    src_d      = src_q;
    io_d       = io_q;
    cnt_d      = cnt_q + CNT_W'(1);
    if (acc) begin
      prev_a_d   = cpu_a_i;
      prev_wr_d  = cpu_wr_i;
      prev_vld_d = 1'b1;
    end
    if (rd_acc) begin
      if (!io_hit) begin
        src_d = SRC_RAM;
      end else if (io_off == OFF_DATA) begin
        src_d = SRC_RX;
        io_d  = rx_full_q ? rx_data_q : 8'h00;
      end else if (io_off[2]) begin
        src_d = SRC_CNT;
        case (io_off[1:0])
          2'd0:    io_d = snap_w[7:0];
          2'd1:    io_d = snap_w[15:8];
          2'd2:    io_d = snap_w[23:16];
          default: io_d = snap_w[31:24];
        endcase
      end else begin
        src_d = SRC_ZERO;
      end
    end
  end

  always_comb begin
    rx_full_d = rx_full_q;
    rx_data_d = rx_data_q;
    stop_d    = stop_q;
    tx_push   = 1'b0;
    tx_wdata  = cpu_dout_i;
    if (wr_acc && io_hit) begin
      if ((io_off == OFF_DATA) && (cpu_dout_i != 8'h00)) tx_push = 1'b1;
      if (io_off == OFF_STOP) begin
        tx_push  = 1'b1;
        tx_wdata = 8'h00;
        stop_d   = 1'b1;
      end
    end
    // Pop needs a full buffer and load needs an empty one, so they never collide.
    if (new_rd && io_hit && (io_off == OFF_DATA) && rx_full_q) begin
      rx_full_d = 1'b0;
    end else if (rx_valid_i && !rx_full_q) begin
      rx_full_d = 1'b1;
      rx_data_d = rx_data_i;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      prev_a_q   <= '0;
      prev_wr_q  <= 1'b0;
      prev_vld_q <= 1'b0;
      src_q      <= SRC_ZERO;
      io_q       <= '0;
      rx_full_q  <= 1'b0;
      rx_data_q  <= '0;
      cnt_q      <= '0;
      snap_q     <= '0;
      stop_q     <= 1'b0;
    end else begin
      prev_a_q   <= prev_a_d;
      prev_wr_q  <= prev_wr_d;
      prev_vld_q <= prev_vld_d;
      src_q      <= src_d;
      io_q       <= io_d;
      rx_full_q  <= rx_full_d;
      rx_data_q  <= rx_data_d;
      cnt_q      <= cnt_d;
      snap_q     <= snap_d;
      stop_q     <= stop_d;
    end
  end

  // Read-first RAM: the registered read sees the contents before this edge's write.
  always_ff @(posedge clk_in) begin
    if (wr_acc && !io_hit) ram[ram_addr] <= cpu_dout_i;
    if (rd_acc && !io_hit) ram_q <= ram[ram_addr];
  end

  always_comb begin
    case (src_q)
      SRC_RAM:         cpu_din_o = ram_q;
      SRC_RX, SRC_CNT: cpu_din_o = io_q;
      default:         cpu_din_o = 8'h00;
    endcase
  end

  byte_fifo #(
    .W     (8),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .push_i      (tx_push),
    .push_data_i (tx_wdata),
    .pop_i       (tx_ready_i),
    .pop_data_o  (tx_data_o),
    .full_o      (tx_full),
    .empty_o     (tx_empty),
    .count_o     (tx_cnt)
  );

  a_no_push_when_full: assert property (@(posedge clk_in) disable iff (!rst_in) !(tx_push && tx_full));

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed bench for mem_io_responder: RAM/IO vector table plus RX, TX, stop, reset and counter sequences.
module tb_mem_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic [31:0] cpu_a_i = '0;
  logic [7:0]  cpu_dout_i = '0;
  logic        cpu_wr_i = 1'b0;
  logic [7:0]  cpu_din_o;
  logic        cpu_rdy_o;
  logic [7:0]  rx_data_i = '0;
  logic        rx_valid_i = 1'b0;
  logic        rx_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i = 1'b0;
  logic        prog_stop_o;

  mem_io_responder dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .cpu_a_i     (cpu_a_i),
    .cpu_dout_i  (cpu_dout_i),
    .cpu_wr_i    (cpu_wr_i),
    .cpu_din_o   (cpu_din_o),
    .cpu_rdy_o   (cpu_rdy_o),
    .rx_data_i   (rx_data_i),
    .rx_valid_i  (rx_valid_i),
    .rx_ready_o  (rx_ready_o),
    .tx_data_o   (tx_data_o),
    .tx_valid_o  (tx_valid_o),
    .tx_ready_i  (tx_ready_i),
    .prog_stop_o (prog_stop_o)
  );

  always #5 clk_in = ~clk_in;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  typedef struct {
    logic        wr;
    logic [31:0] a;
    logic [7:0]  d;
    logic        chk;
    logic [7:0]  exp_din;
  } vec_t;

  vec_t vt[12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic wr, input logic [31:0] a, input logic [7:0] d);
    cpu_wr_i   = wr;
    cpu_a_i    = a;
    cpu_dout_i = d;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 8'h00);
  endtask

  task automatic do_reset();
    idle();
    #2 rst_in = 1'b0;
    step();
    step();
    rst_in = 1'b1;
    cyc = 0;
  endtask

  task automatic run_to(input int n);
    idle();
    while (cyc < n) step();
  endtask

  logic [7:0] got[16];
  int         n_got;
  logic       was_rdy;

  initial begin
    vt[0]  = '{1'b1, 32'h0001_0010 & 32'h0000_FFFF, 8'hA5, 1'b0, 8'h00};
    vt[1]  = '{1'b0, 32'h0000_0010, 8'h00, 1'b1, 8'hA5};
    vt[2]  = '{1'b1, 32'h0001_FFFF, 8'h3C, 1'b0, 8'h00};
    vt[3]  = '{1'b0, 32'h0001_FFFF, 8'h00, 1'b1, 8'h3C};
    vt[4]  = '{1'b0, 32'h0000_0010, 8'h00, 1'b1, 8'hA5};
    vt[5]  = '{1'b1, 32'h0003_0000, 8'h00, 1'b0, 8'h00};
    vt[6]  = '{1'b1, 32'h0003_0002, 8'h77, 1'b0, 8'h00};
    vt[7]  = '{1'b0, 32'h0003_0002, 8'h00, 1'b1, 8'h00};
    vt[8]  = '{1'b0, 32'h0003_0000, 8'h00, 1'b1, 8'h00};
    vt[9]  = '{1'b1, 32'h0002_0010, 8'h99, 1'b0, 8'h00};
    vt[10] = '{1'b0, 32'h0000_0010, 8'h00, 1'b1, 8'h99};
    vt[11] = '{1'b0, 32'h0003_0001, 8'h00, 1'b1, 8'h00};

    // Reset values while reset is held
    #3;
    chk("rst_din", cpu_din_o, 8'h00);
    chk("rst_tx_valid", tx_valid_o, 1'b0);
    chk("rst_rx_ready", rx_ready_o, 1'b1);
    chk("rst_stop", prog_stop_o, 1'b0);
    chk("rst_rdy", cpu_rdy_o, 1'b1);
    do_reset();

    // RAM and IO-window vectors, TX held off so any stray push is visible
    tx_ready_i = 1'b0;
    for (int i = 0; i < 12; i++) begin
      drive(vt[i].wr, vt[i].a, vt[i].d);
      step();
      if (vt[i].chk) chk($sformatf("vec%0d_din", i), cpu_din_o, vt[i].exp_din);
      chk($sformatf("vec%0d_tx_valid", i), tx_valid_o, 1'b0);
    end

    // RX: load, held read pops once, later byte survives the hold
    idle();
    rx_data_i = 8'h41; rx_valid_i = 1'b1;
    step();
    rx_valid_i = 1'b0;
    chk("rx_loaded", rx_ready_o, 1'b0);
    drive(1'b0, 32'h0003_0000, 8'h00);
    step();
    chk("rx_pop_data", cpu_din_o, 8'h41);
    chk("rx_ready_after_pop", rx_ready_o, 1'b1);
    rx_data_i = 8'h42; rx_valid_i = 1'b1;
    step();
    rx_valid_i = 1'b0;
    chk("rx_reload_held", rx_ready_o, 1'b0);
    step();
    chk("rx_no_second_pop", rx_ready_o, 1'b0);
    idle();
    step();
    drive(1'b0, 32'h0003_0000, 8'h00);
    step();
    chk("rx_second_byte", cpu_din_o, 8'h42);
    chk("rx_second_popped", rx_ready_o, 1'b1);
    idle();
    step();
    drive(1'b0, 32'h0003_0000, 8'h00);
    step();
    chk("rx_empty_read", cpu_din_o, 8'h00);

    // TX: fill to depth, 9th write stalls, then drains in order
    tx_ready_i = 1'b0;
    drive(1'b1, 32'h0003_0000, 8'h30); step();
    drive(1'b1, 32'h0003_0000, 8'h00); step();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 32'h0003_0000, 8'h31); step();
    end
    chk("tx_full_rdy", cpu_rdy_o, 1'b0);
    chk("tx_head", tx_data_o, 8'h30);
    drive(1'b1, 32'h0003_0000, 8'h31);
    step(); step();
    chk("tx_stall_held", cpu_rdy_o, 1'b0);
    tx_ready_i = 1'b1;
    n_got = 0;
    for (int k = 0; k < 30; k++) begin
      if (tx_valid_o && n_got < 16) begin
        got[n_got] = tx_data_o;
        n_got++;
      end
      was_rdy = cpu_rdy_o;
      step();
      if (was_rdy && cpu_wr_i) idle();
    end
    chk("tx_drain_count", n_got, 9);
    chk("tx_drain_0", got[0], 8'h30);
    for (int k = 1; k < 9; k++) chk($sformatf("tx_drain_%0d", k), got[k], 8'h31);
    chk("tx_rdy_recovered", cpu_rdy_o, 1'b1);

    // Stop: pushes 0x00, freezes the CPU, later writes ignored
    drive(1'b1, 32'h0003_0004, 8'hAB);
    step();
    chk("stop_set", prog_stop_o, 1'b1);
    chk("stop_rdy", cpu_rdy_o, 1'b0);
    chk("stop_tx_valid", tx_valid_o, 1'b1);
    chk("stop_tx_zero", tx_data_o, 8'h00);
    drive(1'b1, 32'h0003_0000, 8'h55);
    step(); step(); step();
    chk("stop_no_push", tx_valid_o, 1'b0);
    chk("stop_sticky", prog_stop_o, 1'b1);
    chk("stop_rdy_stuck", cpu_rdy_o, 1'b0);

    // Reset in the middle of a drain with three bytes queued
    do_reset();
    tx_ready_i = 1'b0;
    drive(1'b1, 32'h0003_0000, 8'h41); step();
    drive(1'b1, 32'h0003_0000, 8'h42); step();
    drive(1'b1, 32'h0003_0000, 8'h43); step();
    drive(1'b0, 32'h0001_FFFF, 8'h00); step();
    chk("pre_rst_din", cpu_din_o, 8'h3C);
    drive(1'b1, 32'h0003_0004, 8'h01); step();
    chk("pre_rst_stop", prog_stop_o, 1'b1);
    tx_ready_i = 1'b1;
    idle();
    step();
    chk("pre_rst_head", tx_data_o, 8'h42);
    #2 rst_in = 1'b0;
    #1;
    chk("async_tx_valid", tx_valid_o, 1'b0);
    chk("async_stop", prog_stop_o, 1'b0);
    chk("async_din", cpu_din_o, 8'h00);
    chk("async_rx_ready", rx_ready_o, 1'b1);
    step();
    rst_in = 1'b1;
    cyc = 0;
    run_to(5);
    drive(1'b0, 32'h0003_0004, 8'h00);
    step();
    chk("cnt_after_rst", cpu_din_o, 8'h05);

    // Counter snapshot: taken once, stable over held and upper-byte reads
    do_reset();
    run_to(100);
    drive(1'b0, 32'h0003_0004, 8'h00);
    step();
    chk("snap_b0", cpu_din_o, 8'h64);
    step();
    chk("snap_b0_hold1", cpu_din_o, 8'h64);
    step();
    chk("snap_b0_hold2", cpu_din_o, 8'h64);
    drive(1'b0, 32'h0003_0005, 8'h00); step(); chk("snap_b1", cpu_din_o, 8'h00);
    drive(1'b0, 32'h0003_0006, 8'h00); step(); chk("snap_b2", cpu_din_o, 8'h00);
    drive(1'b0, 32'h0003_0007, 8'h00); step(); chk("snap_b3", cpu_din_o, 8'h00);
    run_to(511);
    drive(1'b0, 32'h0003_0004, 8'h00); step(); chk("snap511_b0", cpu_din_o, 8'hFF);
    drive(1'b0, 32'h0003_0005, 8'h00); step(); chk("snap511_b1", cpu_din_o, 8'h01);
    drive(1'b0, 32'h0003_0006, 8'h00); step(); chk("snap511_b2", cpu_din_o, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Responder end of the CPU byte-wide memory bus: serves the core's `mem_a`/`mem_dout`/`mem_wr` requests and returns `mem_din`.
- Contains the 128 KB unified RAM, the I/O window at 0x30000–0x30007, a cycle counter, a TX byte FIFO and a 1-entry RX buffer.
- Drives the core's `rdy_in` so the CPU stalls when TX is full or the program has stopped.
- Sits between the `cpu` top and the host UART side.

Parameters:
- RAM_AW, 17, RAM byte-address width (2^17 = 128 KB).
- TX_DEPTH, 8, TX FIFO entries (power of two, ≥2).
- CNT_W, 32, cycle counter width.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset, asynchronous, active-low.
- cpu_a_i  input  32  CPU address; only bits 17:0 are decoded.
- cpu_dout_i  input  8  write data from the CPU.
- cpu_wr_i  input  1  1 = write, 0 = read.
- cpu_din_o  output  8  read data to the CPU.
- cpu_rdy_o  output  1  drives the CPU `rdy_in`.
- rx_data_i  input  8  host input byte.
- rx_valid_i  input  1  rx byte valid.
- rx_ready_o  output  1  RX buffer empty, byte accepted on valid&ready.
- tx_data_o  output  8  output byte to the host.
- tx_valid_o  output  1  TX FIFO non-empty.
- tx_ready_i  input  1  host accepts `tx_data_o`.
- prog_stop_o  output  1  sticky: the program wrote 0x30004.

Behaviour:
- Reset (asynchronous, active-low) values:
  - `cpu_din_o` = 0.
  - TX FIFO empty; `tx_valid_o` = 0.
  - RX buffer empty; `rx_ready_o` = 1.
  - Counter = 0.
  - `prog_stop_o` = 0.
  - RAM contents are not reset.
- Decode:
  - IO when `cpu_a_i[17:16]` == 2'b11; otherwise RAM at `cpu_a_i[RAM_AW-1:0]`.
  - IO byte offset = `cpu_a_i[2:0]`. Offsets 1–3 read 0, and writes to them are ignored.
- Accept qualifier: `acc = cpu_rdy_o`. When `cpu_rdy_o` = 0, nothing is accepted and no state changes except the counter, the TX drain and RX fill.
- `cpu_rdy_o` (combinational) = !`prog_stop_o` && (TX count < TX_DEPTH).
  - While `cpu_rdy_o` is low, the frozen CPU holds its request; it is taken on the first cycle `cpu_rdy_o` returns high.
- RAM write: when `acc` && `cpu_wr_i` && RAM region, `ram[addr]` <= `cpu_dout_i` at the clock edge.
- Read latency is 1 cycle:
  - A read presented in cycle N appears on `cpu_din_o` in cycle N+1 (registered).
  - The source select is registered alongside, so that `cpu_din_o` is a registered mux.
- Read-while-write to the same RAM address: `cpu_din_o` returns the old value (read-first).
- "New access" = `acc` && read && (address differs from the previous accepted address, or the previous accepted access was a write).
- Read 0x30000:
  - Returns the RX buffer byte if full, else 0x00.
  - On a new access with the buffer full, the buffer is cleared (pop).
  - A held address never pops twice.
- Read 0x30004–0x30007:
  - A new access to 0x30004 snapshots the counter.
  - Bytes 4..7 return snapshot[7:0], [15:8], [23:16], [31:24] (little-endian).
  - 0x30005–0x30007 never re-snapshot.
- Counter: +1 every cycle after reset, independent of `cpu_rdy_o`; wraps 0xFFFFFFFF → 0.
- Write 0x30000: a nonzero byte is pushed into the TX FIFO; 0x00 is ignored.
- Write 0x30004:
  - Pushes 0x00 into the TX FIFO (the only path for a 0x00 byte).
  - Sets `prog_stop_o`, which holds until reset.
  - `cpu_rdy_o` then stays low permanently.
- TX FIFO:
  - Circular buffer with `log2(TX_DEPTH)+1`-bit count.
  - Pop when `tx_valid_o` && `tx_ready_i`.
  - Push and pop in the same cycle are both honoured; count unchanged.
  - A push is never presented while full, because `acc` = 0.
- RX buffer:
  - Loads on `rx_valid_i` && `rx_ready_o`.
  - A pop and a load in the same cycle cannot occur (`rx_ready_o` = 0 while full); the load happens the cycle after the pop.
- Reset mid-transfer: FIFO and buffer contents are discarded, the in-flight read is dropped, and `cpu_din_o` = 0.

Decomposition:
- Shared package holds:
  - `IO_BASE` = 32'h30000, `IO_STOP` = 32'h30004.
  - IO region compare (bits 17:16 = 2'b11).
  - Read-source enum: RAM, RX, CNT, ZERO.
- One sub-module: `byte_fifo` (parametrised by width and depth; push/pop, full/empty, count), used for TX.
- The RAM array is inline.

Test Plan:
- Write 0xA5 to 0x00010, then read 0x00010 → `cpu_din_o` = 0xA5 in the next cycle; a read of 0x1FFFF after writing 0x3C returns 0x3C.
- `rx_valid_i` with 0x41; CPU holds a read of 0x30000 for 3 cycles → 0x41 is returned, popped exactly once; subsequent new read → 0x00; `rx_ready_o` goes high the cycle after the pop.
- Reset, then a read of 0x30004 at cycle 100 (first cycle after reset = 0) → byte0..3 reads return 100, 0, 0, 0, with the snapshot stable across the 4 byte reads.
- `tx_ready_i` = 0; write 0x30, 0x00, 0x31 ×8 → 0x00 is skipped; after 8 pushes `cpu_rdy_o` = 0; raise `tx_ready_i` → bytes drain in order 0x30, 0x31…; `cpu_rdy_o` recovers and the held 9th write lands.
- Write 0x30004 → `prog_stop_o` = 1, `cpu_rdy_o` stuck at 0, TX emits 0x00; a later write to 0x30000 has no effect.
- Assert `rst_in` low mid-TX-drain with 3 bytes queued → `tx_valid_o` = 0 asynchronously, counter = 0, `prog_stop_o` = 0.
